hold_ctrl: RTL

HOLD_CTRL -- requirements
Module: hold_ctrl

---
 rtl/hold_ctrl_pkg.sv | 28 ++
 rtl/hold_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hold_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hold_ctrl_pkg
// Description : Shared widths, hold codes and FSM encodings for hold_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package hold_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int HOLD_W = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [HOLD_W-1:0] hold_t;

    localparam hold_t c_HOLD_NONE = 3'd0;
    localparam hold_t c_HOLD_PC   = 3'd1;
    localparam hold_t c_HOLD_IF   = 3'd2;
    localparam hold_t c_HOLD_EX   = 3'd4;
    localparam hold_t c_HOLD_PPL  = 3'd5;
    localparam hold_t c_HOLD_MEM  = 3'd6;

    localparam logic [1:0] c_ST_RUN       = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_INT_ENTRY = 2'd2;
    localparam logic [1:0] c_ST_INT_RET   = 2'd3;

endpackage : hold_ctrl_pkg
`default_nettype wire

// File: rtl/hold_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hold_ctrl
// Description : Pipeline hold/flush and PC redirect controller. Interrupt
//               entry/return support is built only when HOLD_CTRL_INT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_ctrl
    import hold_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_use,
    input  logic              jump_flag,
    input  logic [DATA_W-1:0] jump_addr,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] ex_inst_addr,
    input  logic              int_req,
    input  logic [DATA_W-1:0] int_vector,
    input  logic              mret,
    output logic [HOLD_W-1:0] hold_flag,
    output logic              pc_jump_flag,
    output logic [DATA_W-1:0] pc_jump_addr,
    output logic              int_ack,
    output logic [DATA_W-1:0] epc
);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [HOLD_W-1:0] w_hold;
    logic              w_pc_jump;
    logic [DATA_W-1:0] w_pc_addr;
    logic              w_accept;
    logic              w_ret;

`ifdef HOLD_CTRL_INT_EN
    logic              r_int_pend;
    logic              r_in_isr;
    logic [DATA_W-1:0] r_epc;
`else
    logic              w_unused;
    assign w_unused = ^{int_req, mret, int_vector, ex_inst_addr};
`endif

    // MEM_WAIT with mem_busy low decides exactly like RUN, so both share the priority chain.
    always_comb begin
        w_hold       = c_HOLD_NONE;
        w_pc_jump    = 1'b0;
        w_pc_addr    = '0;
        w_next_state = c_ST_RUN;
        w_accept     = 1'b0;
        w_ret        = 1'b0;
        case (r_state)
            c_ST_RUN, c_ST_MEM_WAIT: begin
                if (mem_busy) begin
                    w_hold       = c_HOLD_MEM;
                    w_next_state = c_ST_MEM_WAIT;
                end else if (jump_flag) begin
                    w_hold    = c_HOLD_PPL;
                    w_pc_jump = 1'b1;
                    w_pc_addr = jump_addr;
`ifdef HOLD_CTRL_INT_EN
                end else if (mret && r_in_isr) begin
                    w_hold       = c_HOLD_PPL;
                    w_pc_jump    = 1'b1;
                    w_pc_addr    = r_epc;
                    w_ret        = 1'b1;
                    w_next_state = c_ST_INT_RET;
                end else if (r_int_pend) begin
                    w_hold       = c_HOLD_PPL;
                    w_pc_jump    = 1'b1;
                    w_pc_addr    = int_vector;
                    w_accept     = 1'b1;
                    w_next_state = c_ST_INT_ENTRY;
`endif
                end else if (ld_use) begin
                    w_hold = c_HOLD_EX;
                end
            end
`ifdef HOLD_CTRL_INT_EN
            c_ST_INT_ENTRY, c_ST_INT_RET: begin
                w_hold = c_HOLD_PC;
            end
`endif
            default: begin
                w_hold = c_HOLD_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef HOLD_CTRL_INT_EN
    // Acceptance clears the pending flag even if int_req is still high that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_pend <= 1'b0;
            r_in_isr   <= 1'b0;
            r_epc      <= '0;
        end else begin
            if (w_accept) begin
                r_int_pend <= 1'b0;
                r_in_isr   <= 1'b1;
                r_epc      <= ex_inst_addr;
            end else begin
                if (int_req && !r_in_isr) begin
                    r_int_pend <= 1'b1;
                end
                if (w_ret) begin
                    r_in_isr <= 1'b0;
                end
            end
        end
    end

    assign int_ack = rst_n & w_accept;
    assign epc     = r_epc;
`else
    assign int_ack = 1'b0 & w_accept & w_ret;
    assign epc     = '0;
`endif

    // Combinational outputs are gated so reset clears them without waiting for a clock.
    assign hold_flag    = rst_n ? w_hold : c_HOLD_NONE;
    assign pc_jump_flag = rst_n & w_pc_jump;
    assign pc_jump_addr = rst_n ? w_pc_addr : '0;

endmodule : hold_ctrl
`default_nettype wire
